// File: rtl/mem_ctrl.sv
// mem_ctrl: CPU-to-async-SRAM access controller with optional MMIO page
// Ports: clk/rst (sync, active-high); addr/wdata/ram_read/ram_write CPU request;
// mem_busy/mem_ready/mem_bus CPU status and read data; sram_* external SRAM
// address, data and active-low strobes; leds MMIO LED register.
// Macro MEM_CTRL_MMIO_EN maps 0xFF00-0xFFFF to LEDs (0xFF00) and a cycle counter (0xFF01).
module mem_ctrl #(
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        ram_read,
  input  logic        ram_write,
  output logic        mem_busy,
  output logic        mem_ready,
  output logic [15:0] mem_bus,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [7:0]  leds
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  // zero wait states is stretched to one
  localparam logic [3:0] WS_LAST = (WAIT_STATES < 2) ? 4'd0 : 4'(WAIT_STATES - 1);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [15:0] addr_q, wdata_q, mmio_rdata;
  logic rd_q, req, mmio, strobe;
  assign req = ram_read | ram_write;
`ifdef MEM_CTRL_MMIO_EN
  logic [15:0] cyc;
  logic [7:0] led_q;
  assign mmio = addr[15:8] == 8'hFF;
  assign mmio_rdata = addr == 16'hFF00 ? {8'h00, led_q} : addr == 16'hFF01 ? cyc : 16'h0000;
  assign leds = led_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc <= '0;
      led_q <= '0;
    end else begin
      cyc <= cyc + 16'd1;
      if (state == IDLE && ram_write && !ram_read && addr == 16'hFF00) led_q <= wdata[7:0];
    end
  end
`else
  assign mmio = 1'b0;
  assign mmio_rdata = 16'h0000;
  assign leds = 8'h00;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req ? (mmio ? DONE : SETUP) : IDLE;
      SETUP:   state_nx = ACCESS;
      ACCESS:  state_nx = cnt == 4'd0 ? DONE : ACCESS;
      default: state_nx = IDLE;
    endcase
    strobe = state == SETUP || state == ACCESS;
    mem_busy = state != IDLE;
    mem_ready = state == DONE;
    sram_addr = addr_q;
    sram_dq_o = wdata_q;
    sram_ce_n = !strobe;
    sram_oe_n = !(state == ACCESS && rd_q);
    sram_we_n = !(state == ACCESS && !rd_q);
    sram_dq_oe = strobe && !rd_q;
  end
  // address/data stay latched until the next accepted request, so they never
  // move while a strobe is low
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= 1'b0;
      mem_bus <= '0;
    end else begin
      cnt <= state == SETUP ? WS_LAST : state == ACCESS ? cnt - 4'd1 : cnt;
      if (state == IDLE && req) begin
        addr_q <= addr;
        wdata_q <= wdata;
        rd_q <= ram_read;
        if (mmio && ram_read) mem_bus <= mmio_rdata;
      end
      if (state == ACCESS && cnt == 4'd0 && rd_q) mem_bus <= sram_dq_i;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven check of mem_ctrl with an SRAM model
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] addr = '0, wdata = '0;
  logic ram_read = 1'b0, ram_write = 1'b0;
  logic mem_busy, mem_ready, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [15:0] mem_bus, sram_addr, sram_dq_o, sram_dq_i;
  logic [7:0] leds;
  logic z_busy, z_ready, z_dq_oe, z_ce_n, z_oe_n, z_we_n;
  logic [15:0] z_bus, z_addr, z_dq_o;
  logic [7:0] z_leds;
  logic [15:0] mem [0:65535];
  int pass_cnt = 0, total = 0, ecnt = 0, req_e = 0;
  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;
  always @(posedge clk) if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;
  mem_ctrl #(.WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .ram_read(ram_read), .ram_write(ram_write),
    .mem_busy(mem_busy), .mem_ready(mem_ready), .mem_bus(mem_bus), .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .leds(leds));
  mem_ctrl #(.WAIT_STATES(0)) dut_z (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .ram_read(ram_read), .ram_write(ram_write),
    .mem_busy(z_busy), .mem_ready(z_ready), .mem_bus(z_bus), .sram_addr(z_addr),
    .sram_dq_o(z_dq_o), .sram_dq_oe(z_dq_oe), .sram_dq_i(sram_dq_i), .sram_ce_n(z_ce_n),
    .sram_oe_n(z_oe_n), .sram_we_n(z_we_n), .leds(z_leds));
  typedef struct {
    bit rd;
    bit wr;
    logic [15:0] a;
    logic [15:0] d;
    int lat;
    int latz;
    int wec;
    int oec;
    int cec;
    logic [15:0] bus;
    logic [7:0] led;
  } vec_t;
  vec_t v [10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic do_access(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                           output int lat, output int latz, output int wec, output int oec,
                           output int cec, output int dqbad);
    lat = 0; latz = 0; wec = 0; oec = 0; cec = 0; dqbad = 0;
    @(negedge clk);
    ram_read = rd; ram_write = wr; addr = a; wdata = d;
    @(posedge clk);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        ram_read = 1'b0; ram_write = 1'b0; req_e = ecnt;
      end
      wec += int'(!sram_we_n);
      oec += int'(!sram_oe_n);
      cec += int'(!sram_ce_n);
      if (!sram_we_n && (sram_dq_o !== d || sram_addr !== a)) dqbad++;
      if (z_ready && latz == 0) latz = k;
      if (mem_ready) lat = k;
    end
    @(negedge clk);
    chk("ready_single_pulse", mem_ready, 0);
    chk("idle_after_done", mem_busy, 0);
  endtask
  initial begin
    int lat, latz, wec, oec, cec, dqbad, rc, wc, rl, r1, r2;
    logic [15:0] v1;
    int e1;
    #200000 $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, latz, wec, oec, cec, dqbad, rc, wc, rl, r1, r2, e1;
    logic [15:0] v1;
    v[0] = '{1'b0, 1'b1, 16'h0010, 16'h1234, 4, 3, 2, 0, 3, 16'h0000, 8'h00};
    v[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 4, 3, 0, 2, 3, 16'h1234, 8'h00};
    v[2] = '{1'b0, 1'b1, 16'h0011, 16'hBEEF, 4, 3, 2, 0, 3, 16'h1234, 8'h00};
    v[3] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 4, 3, 0, 2, 3, 16'hBEEF, 8'h00};
    v[4] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 4, 3, 0, 2, 3, 16'h1234, 8'h00};
    v[5] = '{1'b0, 1'b1, 16'h0020, 16'hCAFE, 4, 3, 2, 0, 3, 16'h1234, 8'h00};
    v[6] = '{1'b1, 1'b1, 16'h0020, 16'h7777, 4, 3, 0, 2, 3, 16'hCAFE, 8'h00};
    v[7] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 4, 3, 0, 2, 3, 16'hCAFE, 8'h00};
`ifdef MEM_CTRL_MMIO_EN
    v[8] = '{1'b0, 1'b1, 16'hFF00, 16'h00A5, 1, 1, 0, 0, 0, 16'hCAFE, 8'hA5};
    v[9] = '{1'b1, 1'b0, 16'hFF00, 16'h0000, 1, 1, 0, 0, 0, 16'h00A5, 8'hA5};
`else
    v[8] = '{1'b0, 1'b1, 16'hFF00, 16'h5555, 4, 3, 2, 0, 3, 16'hCAFE, 8'h00};
    v[9] = '{1'b1, 1'b0, 16'hFF00, 16'h0000, 4, 3, 0, 2, 3, 16'h5555, 8'h00};
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", mem_busy, 0);
    chk("rst_ready", mem_ready, 0);
    chk("rst_bus", mem_bus, 16'h0000);
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_leds", leds, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_access(v[i].rd, v[i].wr, v[i].a, v[i].d, lat, latz, wec, oec, cec, dqbad);
      chk($sformatf("v%0d_latency", i), lat, v[i].lat);
      chk($sformatf("v%0d_latency_ws0", i), latz, v[i].latz);
      chk($sformatf("v%0d_we_low_cycles", i), wec, v[i].wec);
      chk($sformatf("v%0d_oe_low_cycles", i), oec, v[i].oec);
      chk($sformatf("v%0d_ce_low_cycles", i), cec, v[i].cec);
      chk($sformatf("v%0d_write_addr_data_stable", i), dqbad, 0);
      chk($sformatf("v%0d_mem_bus", i), mem_bus, v[i].bus);
      chk($sformatf("v%0d_leds", i), leds, v[i].led);
    end
    // both requests high, then a second request raised while busy
    rc = 0; wc = 0; rl = 0;
    @(negedge clk);
    ram_read = 1'b1; ram_write = 1'b1; addr = 16'h0020; wdata = 16'h7777;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin ram_read = 1'b0; ram_write = 1'b0; end
      if (k == 2) begin ram_write = 1'b1; addr = 16'h0030; wdata = 16'h9999; end
      if (k == 5) ram_write = 1'b0;
      rc += int'(mem_ready);
      wc += int'(!sram_we_n);
      if (mem_ready) rl = k;
    end
    chk("busy_req_ready_count", rc, 1);
    chk("busy_req_ready_cycle", rl, 4);
    chk("busy_req_no_write", wc, 0);
    chk("busy_req_bus", mem_bus, 16'hCAFE);
    // back-to-back reads: one completion every WAIT_STATES+3 cycles
    r1 = 0; r2 = 0;
    @(negedge clk);
    ram_read = 1'b1; addr = 16'h0010;
    for (int k = 1; k <= 30 && r2 == 0; k++) begin
      @(negedge clk);
      if (mem_ready && r1 == 0) r1 = k;
      else if (mem_ready) r2 = k;
    end
    ram_read = 1'b0;
    chk("b2b_period", r2 - r1, 5);
    chk("b2b_bus", mem_bus, 16'h1234);
    repeat (8) @(negedge clk);
`ifdef MEM_CTRL_MMIO_EN
    do_access(1'b1, 1'b0, 16'hFF01, 16'h0000, lat, latz, wec, oec, cec, dqbad);
    v1 = mem_bus; e1 = req_e;
    repeat (7) @(negedge clk);
    do_access(1'b1, 1'b0, 16'hFF01, 16'h0000, lat, latz, wec, oec, cec, dqbad);
    chk("mmio_counter_delta", 16'(mem_bus - v1), 16'(req_e - e1));
    chk("mmio_counter_latency", lat, 1);
    do_access(1'b0, 1'b1, 16'hFF01, 16'h1111, lat, latz, wec, oec, cec, dqbad);
    do_access(1'b1, 1'b0, 16'hFF07, 16'h0000, lat, latz, wec, oec, cec, dqbad);
    chk("mmio_other_reads_zero", mem_bus, 16'h0000);
    chk("mmio_other_no_sram", cec, 0);
    chk("mmio_leds_kept", leds, 8'hA5);
`endif
    // reset in the middle of a write access
    @(negedge clk);
    ram_write = 1'b1; addr = 16'h0040; wdata = 16'h4444;
    @(posedge clk);
    @(negedge clk);
    ram_write = 1'b0;
    @(negedge clk);
    chk("abort_we_active", sram_we_n, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("abort_dq_oe", sram_dq_oe, 0);
    chk("abort_busy", mem_busy, 0);
    chk("abort_bus", mem_bus, 16'h0000);
    chk("abort_leds", leds, 8'h00);
    rc = int'(mem_ready);
    repeat (8) begin
      @(negedge clk);
      rc += int'(mem_ready);
    end
    chk("abort_no_ready", rc, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
